du_ex_register_way0: RTL

- Pipeline register between DecoderUnit_way0 (upstream) and the way0 execute unit (downstream). It carries the decoded instruction bundle across the stage boundary.
- Implemented as a 2-entry skid buffer with a valid/ready handshake on both sides. Sustains one instruction per cycle while keeping ready_o a registered signal, so there is no combinational ready path from EX back to DU.
- Flushes all held instructions on a jump.

---
 rtl/core_way0_pkg.sv | 34 +++
 rtl/skid_buffer_2entry.sv | 97 +++++++++
 rtl/du_ex_register_way0.sv | 82 ++++++++
 3 files changed

// File: rtl/core_way0_pkg.sv
// Shared types and widths for the way0 decode/execute boundary.
//   du_bundle_t  : decoded instruction bundle handed from DU to EX
//   skid_state_t : occupancy state of the 2-entry pipeline register
package core_way0_pkg;

    localparam int DATA_W   = 32;
    localparam int PID_W    = 2;
    localparam int OPCODE_W = 7;
    localparam int FUNCT3_W = 3;
    localparam int FUNCT7_W = 7;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;

    typedef struct packed {
        logic [PID_W-1:0]    pID;
        logic [DATA_W-1:0]   instAddr;
        logic [REG_W-1:0]    rdAddr;
        logic                rdWriteEnable;
        logic [DATA_W-1:0]   rs1ReadData;
        logic [DATA_W-1:0]   rs2ReadData;
        logic [DATA_W-1:0]   imm;
        logic [OPCODE_W-1:0] opCode;
        logic [FUNCT3_W-1:0] funct3;
        logic [FUNCT7_W-1:0] funct7;
        logic [SHAMT_W-1:0]  shamt;
    } du_bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/skid_buffer_2entry.sv
// Generic 2-entry skid buffer with valid/ready handshake on both sides and
// a synchronous flush.
//   clk, reset_n        : clock, asynchronous active-low reset
//   valid_i/ready_o     : upstream handshake, data_i sampled on accept
//   flush_i             : drop everything held and anything offered this cycle
//   valid_o/ready_i     : downstream handshake, data_o driven from entry M
//   occupancy_o         : number of held entries (0..2)
// ready_o is decoded from the state flops only, so there is no
// combinational path from ready_i to ready_o.
module skid_buffer_2entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   occupancy_o
);
    import core_way0_pkg::*;

    skid_state_t  state_q, state_d;
    logic [W-1:0] m_q, m_d;   // main entry, always the oldest held item
    logic [W-1:0] s_q, s_d;   // skid entry, only valid in TWO
    logic         acc, iss;

    assign ready_o = (state_q != TWO);
    assign valid_o = (state_q != EMPTY);
    assign acc     = valid_i & ready_o;
    assign iss     = valid_o & ready_i;

    // Stale M content is masked so nothing leaks while the output is invalid.
    assign data_o  = valid_o ? m_q : '0;

    always_comb begin
        occupancy_o = 2'd0;
        case (state_q)
            ONE:     occupancy_o = 2'd1;
            TWO:     occupancy_o = 2'd2;
            default: occupancy_o = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush_i) begin
            // Offered input is dropped; a completing issue needs no bookkeeping.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        m_d     = data_i;
                    end
                end
                ONE: begin
                    if (acc && iss) begin
                        m_d = data_i;
                    end else if (acc) begin
                        state_d = TWO;
                        s_d     = data_i;
                    end else if (iss) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // Promote the skid entry so FIFO order is preserved.
                    if (iss) begin
                        state_d = ONE;
                        m_d     = s_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

endmodule

// File: rtl/du_ex_register_way0.sv
// Pipeline register between DecoderUnit_way0 and the way0 execute unit.
// Packs the decoded fields into du_bundle_t, passes them through a 2-entry
// skid buffer and unpacks them bit-exact on the EX side.
//   clk, reset_n         : clock, asynchronous active-low reset
//   valid_i/ready_o      : DU side handshake
//   jumpFlag_i           : flush all held and offered instructions
//   *_i                  : decoded bundle from DU
//   valid_o/ready_i      : EX side handshake
//   *_o                  : registered bundle to EX
//   occupancy_o          : entries held (0..2)
module du_ex_register_way0 #(
    parameter int DATA_W = 32,
    parameter int PID_W  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              jumpFlag_i,
    input  logic [PID_W-1:0]  pID_i,
    input  logic [DATA_W-1:0] instAddr_i,
    input  logic [4:0]        rdAddr_i,
    input  logic              rdWriteEnable_i,
    input  logic [DATA_W-1:0] rs1ReadData_i,
    input  logic [DATA_W-1:0] rs2ReadData_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [6:0]        opCode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [4:0]        shamt_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [PID_W-1:0]  pID_o,
    output logic [DATA_W-1:0] instAddr_o,
    output logic [4:0]        rdAddr_o,
    output logic              rdWriteEnable_o,
    output logic [DATA_W-1:0] rs1ReadData_o,
    output logic [DATA_W-1:0] rs2ReadData_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [6:0]        opCode_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [4:0]        shamt_o,
    output logic [1:0]        occupancy_o
);
    import core_way0_pkg::*;

    localparam int BW = $bits(du_bundle_t);

    du_bundle_t in_b, out_b;

    // Field order matches du_bundle_t declaration order.
    assign in_b = {pID_i, instAddr_i, rdAddr_i, rdWriteEnable_i,
                   rs1ReadData_i, rs2ReadData_i, imm_i,
                   opCode_i, funct3_i, funct7_i, shamt_i};

    skid_buffer_2entry #(.W(BW)) u_skid (
        .clk         (clk),
        .reset_n     (reset_n),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .flush_i     (jumpFlag_i),
        .data_i      (in_b),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (out_b),
        .occupancy_o (occupancy_o)
    );

    assign pID_o           = out_b.pID;
    assign instAddr_o      = out_b.instAddr;
    assign rdAddr_o        = out_b.rdAddr;
    assign rdWriteEnable_o = out_b.rdWriteEnable;
    assign rs1ReadData_o   = out_b.rs1ReadData;
    assign rs2ReadData_o   = out_b.rs2ReadData;
    assign imm_o           = out_b.imm;
    assign opCode_o        = out_b.opCode;
    assign funct3_o        = out_b.funct3;
    assign funct7_o        = out_b.funct7;
    assign shamt_o         = out_b.shamt;

endmodule
